// File: rtl/rvc_asap_vga_fetch_ctrl.sv
// VGA display engine: generates raster timing and streams a linear 1/2/4 bpp
// frame buffer from a synchronous memory read port to 4-bit grey RGB.
module rvc_asap_vga_fetch_ctrl #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          BPP       = 1,
  parameter int          HSCALE    = 1,
  parameter int          VSCALE    = 1,
  parameter int          ADDR_W    = 13,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              CLK_25,
  input  logic              Reset,
  input  logic              DispEn,
  output logic              RdEn,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [31:0]       RdData,
  output logic [3:0]        RED,
  output logic [3:0]        GREEN,
  output logic [3:0]        BLUE,
  output logic              h_sync,
  output logic              v_sync,
  output logic              FrameStart,
  output logic [15:0]       FrameCnt
);

  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LW     = H_ACTIVE / HSCALE;
  localparam int PPW    = 32 / BPP;
  localparam int WPL    = LW / PPW;
  localparam int HCW    = $clog2(HTOTAL);
  localparam int VCW    = $clog2(VTOTAL);
  localparam int HSW    = (HSCALE > 1) ? $clog2(HSCALE) : 1;
  localparam int VSW    = (VSCALE > 1) ? $clog2(VSCALE) : 1;
  localparam int PXW    = $clog2(PPW);
  localparam int WDW    = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WPL_A = ADDR_W'(WPL);

  generate
    if (!(BPP == 1 || BPP == 2 || BPP == 4)) begin : g_bad_bpp
      $error("BPP must be 1, 2 or 4");
    end
    if (!(HSCALE == 1 || HSCALE == 2 || HSCALE == 4)) begin : g_bad_hscale
      $error("HSCALE must be 1, 2 or 4");
    end
    if (!(VSCALE == 1 || VSCALE == 2 || VSCALE == 4)) begin : g_bad_vscale
      $error("VSCALE must be 1, 2 or 4");
    end
    if ((H_ACTIVE % HSCALE) != 0 || (LW % PPW) != 0 || WPL < 1) begin : g_bad_line
      $error("line must hold a whole number of logical pixels and words");
    end
    if (PPW * HSCALE < 8) begin : g_bad_period
      $error("word period must be at least 8 cycles");
    end
  endgenerate

  logic [HCW-1:0]    hcnt_reg, hcnt_next;
  logic [VCW-1:0]    vcnt_reg, vcnt_next;
  logic [HSW-1:0]    hs_cnt_reg, hs_cnt_next;
  logic [PXW-1:0]    px_cnt_reg, px_cnt_next;
  logic [WDW-1:0]    wd_cnt_reg, wd_cnt_next;
  logic [VSW-1:0]    vs_cnt_reg, vs_cnt_next;
  logic [ADDR_W-1:0] line_base_reg, line_base_next;
  logic              frame_en_reg, frame_en_next;
  logic              first_reg;
  logic [31:0]       cur_word_reg, cur_word_next;
  logic [31:0]       next_word_reg, next_word_next;
  logic              rd_pend_reg;
  logic [3:0]        colour_reg, colour_next;
  logic              h_sync_reg, h_sync_next;
  logic              v_sync_reg, v_sync_next;
  logic              frame_start_reg, frame_start_next;
  logic [15:0]       frame_cnt_reg, frame_cnt_next;

  logic              line_end, last_line, frame_top;
  logic              h_act, v_act, frame_en_cur;
  logic              boundary, word_rd, prefetch;
  logic [31:0]       word_sel;
  logic [4:0]        shamt;
  logic [BPP-1:0]    pix;
  logic [3:0]        grey;

  assign line_end  = (hcnt_reg == HCW'(HTOTAL - 1));
  assign last_line = (vcnt_reg == VCW'(VTOTAL - 1));
  assign frame_top = (hcnt_reg == '0) && (vcnt_reg == '0);
  assign h_act     = (hcnt_reg < HCW'(H_ACTIVE));
  assign v_act     = (vcnt_reg < VCW'(V_ACTIVE));

  // The enable captured at the top of the frame must already govern that cycle.
  assign frame_en_cur = frame_top ? (DispEn && !first_reg) : frame_en_reg;

  assign boundary = h_act && v_act && (hs_cnt_reg == '0) && (px_cnt_reg == '0);
  assign word_rd  = boundary && frame_en_cur && (wd_cnt_reg < WDW'(WPL - 1));

  // Line-0 prefetch happens before the next frame's enable is captured, so it
  // follows the live DispEn; other prefetches follow the current frame.
  assign prefetch = (hcnt_reg == HCW'(HTOTAL - 2)) &&
                    ((last_line && DispEn) ||
                     ((vcnt_reg < VCW'(V_ACTIVE - 1)) && frame_en_cur));

  assign RdEn   = Reset && (prefetch || word_rd);
  assign RdAddr = line_base_reg + (word_rd ? (ADDR_W'(wd_cnt_reg) + ADDR_W'(1)) : '0);

  // At a boundary CurWord is only being loaded, so pixel 0 comes from NextWord.
  assign word_sel = boundary ? next_word_reg : cur_word_reg;
  assign shamt    = 5'(px_cnt_reg) * 5'(BPP);
  assign pix      = BPP'(word_sel >> shamt);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grey
      assign grey[gi] = pix[gi % BPP];
    end
  endgenerate

  always_comb begin
    hcnt_next        = line_end ? '0 : hcnt_reg + HCW'(1);
    vcnt_next        = vcnt_reg;
    hs_cnt_next      = '0;
    px_cnt_next      = '0;
    wd_cnt_next      = '0;
    vs_cnt_next      = vs_cnt_reg;
    line_base_next   = line_base_reg;
    frame_en_next    = frame_en_reg;
    cur_word_next    = cur_word_reg;
    next_word_next   = next_word_reg;
    frame_cnt_next   = frame_cnt_reg;
    colour_next      = '0;
    h_sync_next      = 1'b1;
    v_sync_next      = 1'b1;
    frame_start_next = frame_top;

    if (line_end) begin
      vcnt_next = last_line ? '0 : vcnt_reg + VCW'(1);
      if (v_act)
        vs_cnt_next = (vs_cnt_reg == VSW'(VSCALE - 1)) ? '0 : vs_cnt_reg + VSW'(1);
      else
        vs_cnt_next = '0;
    end

    if (line_end && last_line)
      frame_cnt_next = frame_cnt_reg + 16'd1;

    if (frame_top)
      frame_en_next = DispEn && !first_reg;

    // Logical pixel position within the visible part of the line.
    if (h_act) begin
      hs_cnt_next = (hs_cnt_reg == HSW'(HSCALE - 1)) ? '0 : hs_cnt_reg + HSW'(1);
      px_cnt_next = px_cnt_reg;
      wd_cnt_next = wd_cnt_reg;
      if (hs_cnt_reg == HSW'(HSCALE - 1)) begin
        px_cnt_next = (px_cnt_reg == PXW'(PPW - 1)) ? '0 : px_cnt_reg + PXW'(1);
        if (px_cnt_reg == PXW'(PPW - 1))
          wd_cnt_next = (wd_cnt_reg == WDW'(WPL - 1)) ? '0 : wd_cnt_reg + WDW'(1);
      end
    end

    // Base moves on once the visible part of the last replica line is done,
    // well ahead of the end-of-line prefetch.
    if (!v_act)
      line_base_next = BASE;
    else if ((hcnt_reg == HCW'(H_ACTIVE)) && (vs_cnt_reg == VSW'(VSCALE - 1)))
      line_base_next = line_base_reg + WPL_A;

    if (boundary)
      cur_word_next = next_word_reg;
    if (rd_pend_reg)
      next_word_next = RdData;

    if (h_act && v_act && frame_en_cur)
      colour_next = grey;

    if ((int'(hcnt_reg) >= H_ACTIVE + H_FP) && (int'(hcnt_reg) < H_ACTIVE + H_FP + H_SYNC))
      h_sync_next = 1'b0;
    if ((int'(vcnt_reg) >= V_ACTIVE + V_FP) && (int'(vcnt_reg) < V_ACTIVE + V_FP + V_SYNC))
      v_sync_next = 1'b0;
  end

  always_ff @(posedge CLK_25) begin
    if (!Reset) begin
      hcnt_reg        <= '0;
      vcnt_reg        <= '0;
      hs_cnt_reg      <= '0;
      px_cnt_reg      <= '0;
      wd_cnt_reg      <= '0;
      vs_cnt_reg      <= '0;
      line_base_reg   <= BASE;
      frame_en_reg    <= 1'b0;
      first_reg       <= 1'b1;
      cur_word_reg    <= '0;
      next_word_reg   <= '0;
      rd_pend_reg     <= 1'b0;
      colour_reg      <= '0;
      h_sync_reg      <= 1'b1;
      v_sync_reg      <= 1'b1;
      frame_start_reg <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      hcnt_reg        <= hcnt_next;
      vcnt_reg        <= vcnt_next;
      hs_cnt_reg      <= hs_cnt_next;
      px_cnt_reg      <= px_cnt_next;
      wd_cnt_reg      <= wd_cnt_next;
      vs_cnt_reg      <= vs_cnt_next;
      line_base_reg   <= line_base_next;
      frame_en_reg    <= frame_en_next;
      first_reg       <= 1'b0;
      cur_word_reg    <= cur_word_next;
      next_word_reg   <= next_word_next;
      rd_pend_reg     <= RdEn;
      colour_reg      <= colour_next;
      h_sync_reg      <= h_sync_next;
      v_sync_reg      <= v_sync_next;
      frame_start_reg <= frame_start_next;
      frame_cnt_reg   <= frame_cnt_next;
    end
  end

  assign RED        = colour_reg;
  assign GREEN      = colour_reg;
  assign BLUE       = colour_reg;
  assign h_sync     = h_sync_reg;
  assign v_sync     = v_sync_reg;
  assign FrameStart = frame_start_reg;
  assign FrameCnt   = frame_cnt_reg;

endmodule

// File: tb/tb_rvc_asap_vga_fetch_ctrl.sv
// Bench for rvc_asap_vga_fetch_ctrl on a reduced raster (40x10 cycles/lines),
// 4 bpp with 2x2 replication and an address space small enough to wrap.
module tb_rvc_asap_vga_fetch_ctrl;

  localparam int HA = 32, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int BPP = 4, HS = 2, VS = 2, AW = 4, BASE = 15;
  localparam int PPW = 32 / BPP;
  localparam int WPL = (HA / HS) / PPW;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_en;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data = '0;
  logic [3:0]    red, green, blue;
  logic          hs, vs, fs;
  logic [15:0]   fcnt;

  always #20 clk = ~clk;

  rvc_asap_vga_fetch_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .BPP(BPP), .HSCALE(HS), .VSCALE(VS), .ADDR_W(AW), .BASE_ADDR(BASE)
  ) dut (
    .CLK_25(clk), .Reset(rst_n), .DispEn(disp_en),
    .RdEn(rd_en), .RdAddr(rd_addr), .RdData(rd_data),
    .RED(red), .GREEN(green), .BLUE(blue),
    .h_sync(hs), .v_sync(vs), .FrameStart(fs), .FrameCnt(fcnt)
  );

  // Synchronous memory; garbage on idle cycles so stray sampling shows up.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : $urandom;

  int         n_checks = 0;
  int         n_fail = 0;
  int         t = 0;
  bit         phase_b = 1'b0;
  bit         fen [0:15];
  logic [3:0] exp_rgb;
  logic       exp_hs, exp_vs, exp_fs;
  logic [3:0] first_px [0:3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, expv, t);
    end
  endtask

  function automatic logic [3:0] exp_colour(input int h, input int v, input bit en);
    int x, y, addr;
    logic [31:0] w;
    logic [3:0] p;
    if (!(en && h < HA && v < VA)) return 4'd0;
    x = h / HS;
    y = v / VS;
    addr = (BASE + y * WPL + x / PPW) % (1 << AW);
    w = mem[addr];
    p = 4'((w >> ((x % PPW) * BPP)) & ((1 << BPP) - 1));
    case (BPP)
      1:       return {4{p[0]}};
      2:       return {p[1:0], p[1:0]};
      default: return p;
    endcase
  endfunction

  task automatic exp_read(input int h, input int v, input bit en, input bit disp,
                          output bit re, output int addr);
    re = 1'b0;
    addr = 0;
    if (en && v < VA && h < HA && (h % (PPW * HS)) == 0 && h / (PPW * HS) < WPL - 1) begin
      re = 1'b1;
      addr = BASE + (v / VS) * WPL + h / (PPW * HS) + 1;
    end else if (h == HT - 2 && v == VT - 1 && disp) begin
      re = 1'b1;
      addr = BASE;
    end else if (h == HT - 2 && en && v + 1 < VA) begin
      re = 1'b1;
      addr = BASE + ((v + 1) / VS) * WPL;
    end
    addr = addr % (1 << AW);
  endtask

  task automatic check_reset();
    chk("rst_red", red, 0);
    chk("rst_green", green, 0);
    chk("rst_blue", blue, 0);
    chk("rst_hsync", hs, 1);
    chk("rst_vsync", vs, 1);
    chk("rst_rden", rd_en, 0);
    chk("rst_rdaddr", rd_addr, BASE);
    chk("rst_fstart", fs, 0);
    chk("rst_fcnt", fcnt, 0);
  endtask

  task automatic start_model();
    t = 0;
    for (int i = 0; i < 16; i++) fen[i] = 1'b0;
    exp_rgb = 4'd0;
    exp_hs = 1'b1;
    exp_vs = 1'b1;
    exp_fs = 1'b0;
  endtask

  // Called #1 after a rising edge; checks cycle t, then advances one clock.
  task automatic model_cycle();
    int h, v, f, addr;
    bit re;
    h = t % HT;
    v = (t / HT) % VT;
    f = t / FRAME;
    if (h == 0 && v == 3) begin
      if (f == 2)     disp_en = 1'b0;
      else if (f < 4) disp_en = 1'b1;
      else            disp_en = 1'($urandom_range(0, 1));
    end
    if (h == 0 && v == 0) fen[f] = (t == 0) ? 1'b0 : disp_en;

    chk("red", red, exp_rgb);
    chk("green", green, exp_rgb);
    chk("blue", blue, exp_rgb);
    chk("hsync", hs, exp_hs);
    chk("vsync", vs, exp_vs);
    chk("fstart", fs, exp_fs);
    chk("fcnt", fcnt, 16'(f));
    exp_read(h, v, fen[f], disp_en, re, addr);
    chk("rden", rd_en, re);
    if (re) chk("rdaddr", rd_addr, addr);

    if (phase_b && t == FRAME) chk("wrap_addr", rd_addr, 0);
    if (phase_b && t > FRAME && t <= FRAME + 4) chk("first_px", red, first_px[t - FRAME - 1]);

    exp_rgb = exp_colour(h, v, fen[f]);
    exp_hs = !(h >= HA + HFP && h < HA + HFP + HSY);
    exp_vs = !(v >= VA + VFP && v < VA + VFP + VSY);
    exp_fs = (h == 0 && v == 0);

    @(posedge clk);
    #1;
    t++;
  endtask

  initial begin
    first_px[0] = 4'h3;
    first_px[1] = 4'h3;
    first_px[2] = 4'hA;
    first_px[3] = 4'hA;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[BASE] = 32'h0000_00A3;

    rst_n = 1'b0;
    disp_en = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_reset();
    end

    rst_n = 1'b1;
    start_model();
    repeat (FRAME + 150) model_cycle();

    rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_reset();
    end

    rst_n = 1'b1;
    disp_en = 1'b1;
    phase_b = 1'b1;
    start_model();
    repeat (8 * FRAME) model_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
